// File: rtl/mux_serializer_pkg.sv
// Shared types and helpers for the mux_serializer parallel-to-serial converter.
package mux_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Depth of a node in a heap-ordered binary tree (root = node 0 at depth 0).
    function automatic int heap_depth(input int node);
        int d;
        d = 0;
        for (int k = 0; k < 30; k++) begin
            if (((node + 1) >> (k + 1)) != 0) d = k + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/mux_serializer_bit_select.sv
// WIDTH:1 bit-select mux built as a heap-ordered tree of 2:1 muxes; sel MSB steers the root.
module bit_select_mux
    import mux_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [$clog2(WIDTH)-1:0] sel,
    output logic                     y
);

    localparam int SEL_W  = $clog2(WIDTH);
    localparam int N_LEAF = 1 << SEL_W;

    // Leaves occupy the top N_LEAF entries; inner node n has children 2n+1 (sel=0) and 2n+2 (sel=1).
    logic [2*N_LEAF-2:0] tree;

    always_comb begin
        tree = '0;
        tree[N_LEAF-1 +: N_LEAF] = N_LEAF'(data);
        for (int n = N_LEAF - 2; n >= 0; n--) begin
            tree[n] = sel[SEL_W-1-heap_depth(n)] ? tree[2*n+2] : tree[2*n+1];
        end
    end

    assign y = tree[0];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial converter, LSB first, valid/ready on both sides.
// Build option: MUX_SERIALIZER_INVERT_EN inverts the serial bit while ser_valid is high.
//
//   state | meaning
//   IDLE  | no word held, par_ready high
//   SHIFT | word held, presenting word[idx] on the serial port
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_data,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             sel_bit;
    logic             word_done;

    bit_select_mux #(.WIDTH(WIDTH)) u_bit_mux (
        .data (word_q),
        .sel  (idx_q),
        .y    (sel_bit)
    );

    assign ser_valid = (state_q == SHIFT);
    assign ser_last  = ser_valid && (idx_q == IDX_LAST);
    assign word_done = ser_valid && ser_ready && ser_last;
    assign par_ready = (state_q == IDLE) || word_done;

`ifdef MUX_SERIALIZER_INVERT_EN
    logic inv_bit;
    assign inv_bit  = sel_bit ? 1'b0 : 1'b1;
    assign ser_data = ser_valid ? inv_bit : 1'b0;
`else
    assign ser_data = ser_valid ? sel_bit : 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (par_valid) begin
                    word_d  = par_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    if (ser_last) begin
                        idx_d = '0;
                        if (par_valid) word_d  = par_data;
                        else           state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_mux_serializer.sv
// Scoreboard bench for mux_serializer: an 8-bit and a 2-bit instance share clock and reset.
module tb_mux_serializer;

`ifdef MUX_SERIALIZER_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] p8_data = '0;
    logic       p8_valid = 1'b0, p8_ready, s8_data, s8_valid, s8_last, s8_ready = 1'b1;
    logic [1:0] p2_data = '0;
    logic       p2_valid = 1'b0, p2_ready, s2_data, s2_valid, s2_last, s2_ready = 1'b1;

    mux_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .par_data(p8_data), .par_valid(p8_valid), .par_ready(p8_ready),
        .ser_data(s8_data), .ser_valid(s8_valid), .ser_last(s8_last), .ser_ready(s8_ready)
    );

    mux_serializer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .par_data(p2_data), .par_valid(p2_valid), .par_ready(p2_ready),
        .ser_data(s2_data), .ser_valid(s2_valid), .ser_last(s2_last), .ser_ready(s2_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue entries are {last, data} for each serial beat still owed.
    logic [1:0] q8[$];
    logic [1:0] q2[$];
    int beats8 = 0;
    int beats2 = 0;
    bit tog_en = 1'b0;
    bit rnd_en = 1'b0;

    always @(negedge clk) begin
        if (tog_en)      s8_ready = ~s8_ready;
        else if (rnd_en) s8_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        logic exp_ready;
        #2;
        if (rst) begin
            q8.delete();
        end else begin
            exp_ready = (q8.size() == 0) || (s8_ready && q8[0][1]);
            check("w8_par_ready", p8_ready, exp_ready);
            if (q8.size() != 0) begin
                check("w8_ser_valid", s8_valid, 1);
                check("w8_ser_data", s8_data, q8[0][0]);
                check("w8_ser_last", s8_last, q8[0][1]);
                if (s8_ready) begin
                    void'(q8.pop_front());
                    beats8++;
                end
            end else begin
                check("w8_idle_valid", s8_valid, 0);
                check("w8_idle_data", s8_data, 0);
                check("w8_idle_last", s8_last, 0);
            end
            if (p8_valid && exp_ready)
                for (int i = 0; i < 8; i++) q8.push_back({(i == 7), p8_data[i] ^ INV});
        end
    end

    always @(negedge clk) begin
        logic exp_ready;
        #2;
        if (rst) begin
            q2.delete();
        end else begin
            exp_ready = (q2.size() == 0) || (s2_ready && q2[0][1]);
            check("w2_par_ready", p2_ready, exp_ready);
            if (q2.size() != 0) begin
                check("w2_ser_valid", s2_valid, 1);
                check("w2_ser_data", s2_data, q2[0][0]);
                check("w2_ser_last", s2_last, q2[0][1]);
                if (s2_ready) begin
                    void'(q2.pop_front());
                    beats2++;
                end
            end else begin
                check("w2_idle_valid", s2_valid, 0);
                check("w2_idle_data", s2_data, 0);
            end
            if (p2_valid && exp_ready)
                for (int i = 0; i < 2; i++) q2.push_back({(i == 1), p2_data[i] ^ INV});
        end
    end

    task automatic send8(input logic [7:0] w);
        bit acc;
        int n;
        p8_data  = w;
        p8_valid = 1'b1;
        n = 0;
        do begin
            #3;
            acc = p8_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send8_timeout", 0, 1);
        p8_valid = 1'b0;
    endtask

    task automatic send2(input logic [1:0] w);
        bit acc;
        int n;
        p2_data  = w;
        p2_valid = 1'b1;
        n = 0;
        do begin
            #3;
            acc = p2_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send2_timeout", 0, 1);
        p2_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q2.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int b0;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // A5 at full rate
        b0 = beats8;
        send8(8'hA5);
        drain();
        check("t1_beats", beats8 - b0, 8);

        // 0F then F0 back to back
        b0 = beats8;
        send8(8'h0F);
        send8(8'hF0);
        drain();
        check("t2_beats", beats8 - b0, 16);

        // 3C under alternating ready
        b0 = beats8;
        tog_en = 1'b1;
        send8(8'h3C);
        drain();
        tog_en = 1'b0;
        s8_ready = 1'b1;
        check("t3_beats", beats8 - b0, 8);

        // reset mid-word after 3 beats of FF
        b0 = beats8;
        send8(8'hFF);
        n = 0;
        while (beats8 - b0 < 3 && n < 100) begin
            #3;
            if (beats8 - b0 < 3) @(negedge clk);
            n++;
        end
        check("t4_pre_beats", beats8 - b0, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("t4_valid_after_rst", s8_valid, 0);
        check("t4_ready_after_rst", p8_ready, 1);
        @(negedge clk);
        b0 = beats8;
        send8(8'h01);
        drain();
        check("t4_beats", beats8 - b0, 8);

        // WIDTH=2 instance
        b0 = beats2;
        send2(2'b10);
        drain();
        check("t6_beats", beats2 - b0, 2);

        // random words with random backpressure
        b0 = beats8;
        rnd_en = 1'b1;
        for (int i = 0; i < 6; i++) send8(8'($urandom));
        drain();
        rnd_en = 1'b0;
        s8_ready = 1'b1;
        check("rand_beats", beats8 - b0, 48);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
